// File: rtl/time_entry_multi_if.sv
// time_entry_multi_if
//   Keypad/display bundle of the time entry controller.
//   slave  : controller side (takes key_code, drives the entry outputs).
//   master : keypad/clock/display side (drives key_code, observes outputs).
//   key_code   - raw keypad code, 0 = no key
//   now_h/now_m- entered current time, set = one-cycle load pulse
//   timer_h/m  - packed per-timer values, run_enable - timer fully entered
//   digit_ptr  - next digit index (NDIG = done), bitmap - active-low digit select
interface time_entry_multi_if #(
    parameter int NUM_TIMERS = 3
) ();
    localparam int NDIG = 4 * (NUM_TIMERS + 1);
    localparam int PW   = $clog2(NDIG + 1);

    logic [5:0]              key_code;
    logic [4:0]              now_h;
    logic [5:0]              now_m;
    logic                    set;
    logic [5*NUM_TIMERS-1:0] timer_h;
    logic [6*NUM_TIMERS-1:0] timer_m;
    logic [NUM_TIMERS-1:0]   run_enable;
    logic [PW-1:0]           digit_ptr;
    logic [NDIG-1:0]         bitmap;

    modport slave (
        input  key_code,
        output now_h, now_m, set, timer_h, timer_m, run_enable, digit_ptr, bitmap
    );

    modport master (
        output key_code,
        input  now_h, now_m, set, timer_h, timer_m, run_enable, digit_ptr, bitmap
    );
endinterface

// File: rtl/time_entry_multi.sv
// time_entry_multi
//   Keypad-driven HH:MM entry for the current time followed by NUM_TIMERS
//   timers. Digits are validated as typed; BACK, ENTER (skip timer) and
//   RESTART keys are supported.
// Ports:
//   mclk - system clock
//   rst  - synchronous active-high reset
//   bus  - time_entry_multi_if.slave (key_code in; time/timer values, set
//          pulse, run enables, digit pointer and display bitmap out)
// Build option:
//   ENTRY_TIMEOUT_EN - when defined, a partially typed field is cleared
//   after TIMEOUT_CYCLES cycles without a key press.
module time_entry_multi #(
    parameter int NUM_TIMERS     = 3,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              mclk,
    input  logic              rst,
    time_entry_multi_if.slave bus
);
    localparam int NDIG = 4 * (NUM_TIMERS + 1);
    localparam int PW   = $clog2(NDIG + 1);
    localparam logic [PW-1:0] PTR_DONE = PW'(NDIG);

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_DIGIT,
        ACT_RESTART,
        ACT_ENTER,
        ACT_BACK
    } action_t;

    logic [5:0]              key_prev;
    logic                    press;
    action_t                 action;
    logic [3:0]              key_val;

    logic [3:0]              d     [NDIG];
    logic [3:0]              d_nxt [NDIG];
    logic [PW-1:0]           ptr, ptr_nxt, ptr_dec;
    logic [NUM_TIMERS-1:0]   run, run_nxt;
    logic                    set_q, set_nxt;

    logic [PW-3:0]           fld, fld_dec;
    logic [1:0]              pos;
    logic                    done;
    logic [3:0]              cur_h1;
    logic                    digit_ok;

    logic [4:0]              now_h_q, now_h_nxt;
    logic [5:0]              now_m_q, now_m_nxt;
    logic [5*NUM_TIMERS-1:0] th_q, th_nxt;
    logic [6*NUM_TIMERS-1:0] tm_q, tm_nxt;
    logic [NDIG-1:0]         bmp_q, bmp_nxt;

    function automatic logic [4:0] hour_of(input logic [3:0] t, input logic [3:0] u);
        return 5'(t) * 5'd10 + 5'(u);
    endfunction

    function automatic logic [5:0] min_of(input logic [3:0] t, input logic [3:0] u);
        return 6'(t) * 6'd10 + 6'(u);
    endfunction

    assign press   = (key_prev == 6'd0) && (bus.key_code != 6'd0);
    assign done    = (ptr == PTR_DONE);
    assign fld     = ptr[PW-1:2];
    assign pos     = ptr[1:0];
    assign ptr_dec = ptr - PW'(1);
    assign fld_dec = ptr_dec[PW-1:2];

    // Keypad code to action/digit value
    always_comb begin
        action  = ACT_NONE;
        key_val = '0;
        case (bus.key_code)
            6'd16: begin action = ACT_DIGIT; key_val = 4'd0; end
            6'd15: begin action = ACT_DIGIT; key_val = 4'd1; end
            6'd11: begin action = ACT_DIGIT; key_val = 4'd2; end
            6'd7:  begin action = ACT_DIGIT; key_val = 4'd3; end
            6'd14: begin action = ACT_DIGIT; key_val = 4'd4; end
            6'd10: begin action = ACT_DIGIT; key_val = 4'd5; end
            6'd6:  begin action = ACT_DIGIT; key_val = 4'd6; end
            6'd13: begin action = ACT_DIGIT; key_val = 4'd7; end
            6'd9:  begin action = ACT_DIGIT; key_val = 4'd8; end
            6'd5:  begin action = ACT_DIGIT; key_val = 4'd9; end
            6'd1:  action = ACT_RESTART;
            6'd3:  action = ACT_ENTER;
            6'd4:  action = ACT_BACK;
            default: action = ACT_NONE;
        endcase
    end

    // H1 of the field being typed, needed to bound H2 so the hour stays <= 23
    always_comb begin
        cur_h1 = '0;
        for (int unsigned f = 0; f <= NUM_TIMERS; f++) begin
            if (fld == (PW-2)'(f)) cur_h1 = d[4*f];
        end
    end

    always_comb begin
        digit_ok = 1'b0;
        case (pos)
            2'd0: digit_ok = (key_val <= 4'd2);
            2'd1: digit_ok = (6'(cur_h1) * 6'd10 + 6'(key_val)) <= 6'd23;
            2'd2: digit_ok = (key_val <= 4'd5);
            default: digit_ok = 1'b1;
        endcase
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

    logic [IW-1:0] idle_cnt;
    logic          timeout;

    always_ff @(posedge mclk) begin
        if (rst || press) idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
    end

    // Field boundaries are multiples of 4, so pos==0 also covers the done state
    assign timeout = (idle_cnt == IDLE_MAX) && (pos != 2'd0) && !done;
`endif

    always_comb begin
        d_nxt   = d;
        ptr_nxt = ptr;
        run_nxt = run;
        set_nxt = 1'b0;
        if (press) begin
            case (action)
                ACT_RESTART: begin
                    for (int unsigned i = 0; i < NDIG; i++) d_nxt[i] = '0;
                    ptr_nxt = '0;
                    run_nxt = '0;
                    set_nxt = 1'b1;
                end
                ACT_DIGIT: begin
                    if (!done && digit_ok) begin
                        for (int unsigned i = 0; i < NDIG; i++) begin
                            if (PW'(i) == ptr) d_nxt[i] = key_val;
                        end
                        ptr_nxt = ptr + PW'(1);
                        if (fld == '0) begin
                            set_nxt = 1'b1;
                        end else if (pos == 2'd3) begin
                            for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
                                if (fld == (PW-2)'(k + 1)) run_nxt[k] = 1'b1;
                            end
                        end
                    end
                end
                ACT_BACK: begin
                    if (ptr != '0) begin
                        for (int unsigned i = 0; i < NDIG; i++) begin
                            if (PW'(i) == ptr_dec) d_nxt[i] = '0;
                        end
                        ptr_nxt = ptr_dec;
                        if (fld_dec == '0) begin
                            set_nxt = 1'b1;
                        end else begin
                            for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
                                if (fld_dec == (PW-2)'(k + 1)) run_nxt[k] = 1'b0;
                            end
                        end
                    end
                end
                ACT_ENTER: begin
                    if (!done && (fld != '0) && (pos == 2'd0)) ptr_nxt = ptr + PW'(4);
                end
                default: ;
            endcase
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (timeout) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if ((PW-2)'(i / 4) == fld) d_nxt[i] = '0;
            end
            ptr_nxt = {fld, 2'b00};
            if (fld == '0) set_nxt = 1'b1;
        end
`endif
    end

    // Output values are formed from the next digit state so they register
    // on the same edge as the digit itself.
    always_comb begin
        now_h_nxt = hour_of(d_nxt[0], d_nxt[1]);
        now_m_nxt = min_of(d_nxt[2], d_nxt[3]);
        th_nxt    = '0;
        tm_nxt    = '0;
        for (int unsigned k = 0; k < NUM_TIMERS; k++) begin
            th_nxt[5*k +: 5] = hour_of(d_nxt[4*k+4], d_nxt[4*k+5]);
            tm_nxt[6*k +: 6] = min_of(d_nxt[4*k+6], d_nxt[4*k+7]);
        end
        bmp_nxt = '1;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (PW'(i) == ptr_nxt) bmp_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            key_prev <= 6'h3F;
            for (int unsigned i = 0; i < NDIG; i++) d[i] <= '0;
            ptr      <= '0;
            run      <= '0;
            set_q    <= 1'b0;
            now_h_q  <= '0;
            now_m_q  <= '0;
            th_q     <= '0;
            tm_q     <= '0;
            bmp_q    <= {{(NDIG-1){1'b1}}, 1'b0};
        end else begin
            // RESTART holds off a second press while key 1 is still down
            key_prev <= (press && action == ACT_RESTART) ? 6'd1 : bus.key_code;
            d        <= d_nxt;
            ptr      <= ptr_nxt;
            run      <= run_nxt;
            set_q    <= set_nxt;
            now_h_q  <= now_h_nxt;
            now_m_q  <= now_m_nxt;
            th_q     <= th_nxt;
            tm_q     <= tm_nxt;
            bmp_q    <= bmp_nxt;
        end
    end

    assign bus.now_h      = now_h_q;
    assign bus.now_m      = now_m_q;
    assign bus.set        = set_q;
    assign bus.timer_h    = th_q;
    assign bus.timer_m    = tm_q;
    assign bus.run_enable = run;
    assign bus.digit_ptr  = ptr;
    assign bus.bitmap     = bmp_q;
endmodule
